// File: rtl/imem_responder.sv
// Multi-cycle instruction-memory responder: one aligned 16-bit read or preload write at a time,
// with a stall while the access is in flight and a one-cycle done pulse carrying data/err.
module imem_responder #(
    parameter int LATENCY        = 4,
    parameter int MEM_WORDS_LOG2 = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] data_out,
    output logic        done,
    output logic        stall,
    output logic        busy,
    output logic        err
);

    localparam int DEPTH = 1 << MEM_WORDS_LOG2;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                    state;
    logic [3:0]                count;
    logic [MEM_WORDS_LOG2-1:0] req_idx;
    logic [MEM_WORDS_LOG2-1:0] in_idx;
    logic [15:0]               req_data;
    logic                      req_wr;
    logic                      req_err;
    logic                      in_err;
    logic                      accept;
    logic                      unused_addr_bits;

    logic [15:0] mem [DEPTH];

    assign in_idx           = addr[MEM_WORDS_LOG2:1];
    assign in_err           = addr[0] | (rd & wr);
    assign accept           = (state == IDLE) && (rd || wr);
    assign stall            = (state == BUSY) || accept;
    assign unused_addr_bits = ^addr;

    // done/err/data_out are loaded on the transition into RESP so they come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
            data_out <= '0;
            req_idx  <= '0;
            req_data <= '0;
            req_wr   <= 1'b0;
            req_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done     <= 1'b0;
                    err      <= 1'b0;
                    data_out <= '0;
                    if (rd || wr) begin
                        req_idx  <= in_idx;
                        req_data <= data_in;
                        req_wr   <= wr;
                        req_err  <= in_err;
                        count    <= 4'(LATENCY - 1);
                        busy     <= 1'b1;
                        if (LATENCY == 1) begin
                            state    <= RESP;
                            done     <= 1'b1;
                            err      <= in_err;
                            data_out <= (rd && !in_err) ? mem[in_idx] : '0;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    count <= count - 4'd1;
                    if (count == 4'd1) begin
                        state    <= RESP;
                        done     <= 1'b1;
                        err      <= req_err;
                        data_out <= (!req_wr && !req_err) ? mem[req_idx] : '0;
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    done     <= 1'b0;
                    err      <= 1'b0;
                    busy     <= 1'b0;
                    data_out <= '0;
                end
                default: begin
                    state    <= IDLE;
                    done     <= 1'b0;
                    err      <= 1'b0;
                    busy     <= 1'b0;
                    data_out <= '0;
                end
            endcase
        end
    end

    // The write lands at the end of RESP; a reset in that cycle drops it.
    always_ff @(posedge clk) begin
        if (!rst && state == RESP && req_wr && !req_err) begin
            mem[req_idx] <= req_data;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: a LATENCY=4 full-depth instance and a LATENCY=1,
// 256-word instance, each compared against a transaction-level memory model.
module tb_imem_responder;

    logic        clk = 1'b0;
    logic        rst_a, rd_a, wr_a, done_a, stall_a, busy_a, err_a;
    logic [15:0] addr_a, data_in_a, data_out_a;
    logic        rst_b, rd_b, wr_b, done_b, stall_b, busy_b, err_b;
    logic [15:0] addr_b, data_in_b, data_out_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] model_a [int];
    logic [15:0] model_b [int];

    always #5 clk = ~clk;

    imem_responder #(.LATENCY(4), .MEM_WORDS_LOG2(15)) dut_a (
        .clk(clk), .rst(rst_a), .addr(addr_a), .data_in(data_in_a), .rd(rd_a), .wr(wr_a),
        .data_out(data_out_a), .done(done_a), .stall(stall_a), .busy(busy_a), .err(err_a)
    );

    imem_responder #(.LATENCY(1), .MEM_WORDS_LOG2(8)) dut_b (
        .clk(clk), .rst(rst_b), .addr(addr_b), .data_in(data_in_b), .rd(rd_b), .wr(wr_b),
        .data_out(data_out_b), .done(done_b), .stall(stall_b), .busy(busy_b), .err(err_b)
    );

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkFlag(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit b, input logic r, input logic w, input logic [15:0] a,
                         input logic [15:0] d);
        if (b) begin
            rd_b = r; wr_b = w; addr_b = a; data_in_b = d;
        end else begin
            rd_a = r; wr_a = w; addr_a = a; data_in_a = d;
        end
    endtask

    task automatic getOut(input bit b, output logic [15:0] dout, output logic dn, output logic st,
                          output logic bs, output logic er);
        if (b) begin
            dout = data_out_b; dn = done_b; st = stall_b; bs = busy_b; er = err_b;
        end else begin
            dout = data_out_a; dn = done_a; st = stall_a; bs = busy_a; er = err_a;
        end
    endtask

    // Word index as seen by the memory: byte address halved, wrapped to the storage depth.
    function automatic int wordIdx(input bit b, input logic [15:0] a);
        return int'((a >> 1) & (b ? 16'h00FF : 16'h7FFF));
    endfunction

    // Present one request and check every cycle through its done pulse.
    task automatic applyStimulus(input bit b, input logic r, input logic w, input logic [15:0] a,
                                 input logic [15:0] d, input bit noise);
        int unsigned lat;
        logic        e_err, known, dn, st, bs, er;
        logic [15:0] e_data, dout;
        int          idx;
        lat    = b ? 1 : 4;
        e_err  = a[0] | (r & w);
        idx    = wordIdx(b, a);
        known  = 1'b1;
        e_data = 16'h0000;
        if (r && !e_err) begin
            if (b) begin
                known  = model_b.exists(idx);
                e_data = known ? model_b[idx] : 16'h0000;
            end else begin
                known  = model_a.exists(idx);
                e_data = known ? model_a[idx] : 16'h0000;
            end
        end
        for (int k = 0; k <= int'(lat); k++) begin
            if (k == 0)
                drive(b, r, w, a, d);
            else if (noise)
                drive(b, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
            else
                drive(b, 1'b0, 1'b0, 16'h0000, 16'h0000);
            #1;
            getOut(b, dout, dn, st, bs, er);
            checkFlag("stall", st, k < int'(lat));
            checkFlag("done", dn, k == int'(lat));
            checkFlag("busy", bs, k >= 1);
            checkFlag("err", er, (k == int'(lat)) ? e_err : 1'b0);
            if (k != int'(lat))
                checkOutput("data_out_idle", dout, 16'h0000);
            else if (known)
                checkOutput("data_out", dout, e_data);
            @(negedge clk);
        end
        if (w && !r && !e_err) begin
            if (b) model_b[idx] = d;
            else   model_a[idx] = d;
        end
    endtask

    task automatic checkIdle(input bit b, input int n);
        logic        dn, st, bs, er;
        logic [15:0] dout;
        for (int k = 0; k < n; k++) begin
            drive(b, 1'b0, 1'b0, 16'h0000, 16'h0000);
            #1;
            getOut(b, dout, dn, st, bs, er);
            checkFlag("idle_done", dn, 1'b0);
            checkFlag("idle_stall", st, 1'b0);
            checkFlag("idle_busy", bs, 1'b0);
            checkFlag("idle_err", er, 1'b0);
            checkOutput("idle_data_out", dout, 16'h0000);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [15:0] a, d;
        logic        r, w;
        rst_a = 1'b1; rst_b = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        $display("[TB] reset state");
        checkIdle(1'b0, 2);
        checkIdle(1'b1, 2);

        $display("[TB] write then read back");
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0002, 16'h1234, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0);

        $display("[TB] misaligned read");
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0);

        $display("[TB] rd and wr conflict");
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0004, 16'h0F0F, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0004, 16'hBEEF, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0);

        $display("[TB] requests during busy are ignored, re-presented read follows");
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0);

        $display("[TB] reset during a pending write");
        drive(1'b0, 1'b0, 1'b1, 16'h0002, 16'h5555);
        #1;
        checkFlag("midrst_stall0", stall_a, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1;
        checkFlag("midrst_busy1", busy_a, 1'b1);
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        checkIdle(1'b0, 5);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0);

        $display("[TB] reset wins over a same-cycle request");
        rst_a = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000);
        @(negedge clk);
        rst_a = 1'b0;
        checkIdle(1'b0, 5);

        $display("[TB] LATENCY=1, 256 words: aliasing and back-to-back");
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0202, 16'hA5A5, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0202, 16'h0000, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'hFE02, 16'h0000, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0);

        $display("[TB] preload small instance through aliased addresses");
        for (int i = 0; i < 256; i++) begin
            a = 16'(i * 2) | (16'($urandom_range(0, 127)) << 9);
            applyStimulus(1'b1, 1'b0, 1'b1, a, 16'($urandom), 1'b0);
        end

        $display("[TB] random traffic");
        for (int i = 0; i < 150; i++) begin
            r = 1'($urandom_range(0, 1));
            w = r ? ($urandom_range(0, 4) == 0) : 1'b1;
            a = 16'($urandom) & 16'hFFFE;
            if ($urandom_range(0, 7) == 0) a[0] = 1'b1;
            applyStimulus(1'b1, r, w, a, 16'($urandom), 1'($urandom));
        end
        for (int i = 0; i < 120; i++) begin
            r = 1'($urandom_range(0, 1));
            w = r ? ($urandom_range(0, 4) == 0) : 1'b1;
            a = 16'($urandom_range(0, 31) * 2) | (($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h0000);
            if ($urandom_range(0, 7) == 0) a[0] = 1'b1;
            applyStimulus(1'b0, r, w, a, 16'($urandom), 1'($urandom));
        end
        checkIdle(1'b0, 2);
        checkIdle(1'b1, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
